// File: rtl/image_frame_store_if.sv
// Image-port bundle for image_frame_store: upstream load stream, downstream dump
// stream, and the pixel engine's address/data/flag signals.
interface image_frame_store_if #(
  parameter int IMG_LOG2 = 6,
  parameter int PIX_W    = 24
);
  logic [PIX_W-1:0]    s_pix;
  logic                s_valid;
  logic                s_ready;
  logic [PIX_W-1:0]    m_pix;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;
  logic [IMG_LOG2-1:0] row;
  logic [IMG_LOG2-1:0] col;
  logic [PIX_W-1:0]    in_pix;
  logic                out_we;
  logic [PIX_W-1:0]    out_pix;
  logic                mirror_done;
  logic                gray_done;
  logic                filter_done;
  logic                proc_rst;
  logic [2:0]          status;
  logic                frame_done;

  // slave: the frame store itself; master: the environment driving it.
  modport slave (
    input  s_pix, s_valid, m_ready, row, col, out_we, out_pix,
           mirror_done, gray_done, filter_done,
    output s_ready, m_pix, m_valid, m_last, in_pix, proc_rst, status, frame_done
  );

  modport master (
    output s_pix, s_valid, m_ready, row, col, out_we, out_pix,
           mirror_done, gray_done, filter_done,
    input  s_ready, m_pix, m_valid, m_last, in_pix, proc_rst, status, frame_done
  );
endinterface

// File: rtl/image_frame_store.sv
// Single-image frame buffer: LOAD from stream, RUN engine in-place, DUMP to stream.
// Optional macro RUN_CYCLES_EN adds a saturating run_cycles[31:0] counter output.
module image_frame_store #(
  parameter int IMG_LOG2 = 6,
  parameter int PIX_W    = 24
) (
  input  logic clk,
  input  logic rst,
  image_frame_store_if.slave bus
`ifdef RUN_CYCLES_EN
  ,
  output logic [31:0] run_cycles
`endif
);
  localparam int AW = 2 * IMG_LOG2;
  localparam int N  = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DUMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_idx;
  logic            r_s_ready;
  logic            r_m_valid;
  logic            r_m_last;
  logic            r_proc_rst;
  logic            r_frame_done;
  logic [2:0]      r_status;
  logic [PIX_W-1:0] r_mem [N];

  logic            w_load_acc;
  logic            w_run_we;
  logic            w_dump_hs;
  logic [AW-1:0]   w_idx_inc;
  logic [AW-1:0]   w_wr_addr;
  logic [PIX_W-1:0] w_wr_data;

  assign w_load_acc = (r_state == ST_LOAD) && bus.s_valid && r_s_ready;
  assign w_run_we   = (r_state == ST_RUN) && bus.out_we;
  assign w_dump_hs  = (r_state == ST_DUMP) && r_m_valid && bus.m_ready;
  assign w_idx_inc  = r_idx + AW'(1);
  assign w_wr_addr  = w_load_acc ? r_idx : {bus.row, bus.col};
  assign w_wr_data  = w_load_acc ? bus.s_pix : bus.out_pix;

  // Storage carries no reset; writes are blocked only while rst is asserted.
  always_ff @(posedge clk) begin
    if (!rst && (w_load_acc || w_run_we)) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  assign bus.in_pix     = r_mem[{bus.row, bus.col}];
  assign bus.m_pix      = r_mem[r_idx];
  assign bus.s_ready    = r_s_ready;
  assign bus.m_valid    = r_m_valid;
  assign bus.m_last     = r_m_last;
  assign bus.proc_rst   = r_proc_rst;
  assign bus.status     = r_status;
  assign bus.frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_idx        <= '0;
      r_s_ready    <= 1'b1;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_proc_rst   <= 1'b1;
      r_frame_done <= 1'b0;
      r_status     <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_load_acc) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= ST_RUN;
              r_idx      <= '0;
              r_s_ready  <= 1'b0;
              r_proc_rst <= 1'b0;
            end else begin
              r_idx <= w_idx_inc;
            end
          end
        end
        ST_RUN: begin
          r_status <= r_status | {bus.filter_done, bus.gray_done, bus.mirror_done};
          if (bus.filter_done) begin
            r_state    <= ST_DUMP;
            r_idx      <= '0;
            r_m_valid  <= 1'b1;
            r_m_last   <= (LAST_IDX == '0);
            r_proc_rst <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (w_dump_hs) begin
            if (r_m_last) begin
              r_state      <= ST_DONE;
              r_idx        <= '0;
              r_m_valid    <= 1'b0;
              r_m_last     <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_idx    <= w_idx_inc;
              r_m_last <= (w_idx_inc == LAST_IDX);
            end
          end
        end
        ST_DONE: begin
          r_state      <= ST_LOAD;
          r_idx        <= '0;
          r_frame_done <= 1'b0;
          r_status     <= '0;
          r_s_ready    <= 1'b1;
        end
        default: begin
          r_state <= ST_LOAD;
          r_idx   <= '0;
        end
      endcase
    end
  end

`ifdef RUN_CYCLES_EN
  logic [31:0] r_run_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cycles <= '0;
    end else if (w_load_acc && (r_idx == LAST_IDX)) begin
      r_run_cycles <= '0;
    end else if ((r_state == ST_RUN) && (r_run_cycles != '1)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end

  assign run_cycles = r_run_cycles;
`endif
endmodule

// File: tb/tb_image_frame_store.sv
// Scoreboard bench for image_frame_store: random loads, engine writes, dumps
// with varied backpressure, and a reset abort mid-dump.
module tb_image_frame_store;
  localparam int IMG_LOG2 = 6;
  localparam int PIX_W    = 24;
  localparam int N        = 4096;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_frame_store_if #(.IMG_LOG2(IMG_LOG2), .PIX_W(PIX_W)) bus ();
`ifdef RUN_CYCLES_EN
  logic [31:0] run_cycles;
`endif

  image_frame_store #(.IMG_LOG2(IMG_LOG2), .PIX_W(PIX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef RUN_CYCLES_EN
    ,
    .run_cycles(run_cycles)
`endif
  );

  logic [PIX_W-1:0] mdl [N];
  exp_t             sbq [$];
  int unsigned      checks   = 0;
  int unsigned      failures = 0;
  int unsigned      fd_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each dump handshake, checks stall stability.
  bit               stalled = 1'b0;
  logic [PIX_W-1:0] st_pix;
  logic             st_last;
  exp_t             got;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_pix", 32'(bus.m_pix), 32'(st_pix));
        chk("stall_last", 32'(bus.m_last), 32'(st_last));
      end
      stalled = 1'b0;
      if (bus.m_valid) begin
        if (bus.m_ready) begin
          checks++;
          if (sbq.size() == 0) begin
            failures++;
            $display("FAIL dump_unexpected actual=%0h expected=none", bus.m_pix);
          end else begin
            got = sbq.pop_front();
            if (bus.m_pix !== got.pix || bus.m_last !== got.last) begin
              failures++;
              $display("FAIL dump_pix actual=%0h/%0b expected=%0h/%0b",
                       bus.m_pix, bus.m_last, got.pix, got.last);
            end
          end
        end else begin
          stalled = 1'b1;
          st_pix  = bus.m_pix;
          st_last = bus.m_last;
        end
      end
      if (bus.frame_done) fd_count++;
    end
  end

  task automatic load_frame(input bit ramp, input int unsigned pct);
    int unsigned n   = 0;
    int unsigned cyc = 0;
    logic [PIX_W-1:0] px;
    // engine writes during LOAD must be ignored
    bus.out_we  = 1'b1;
    bus.row     = '0;
    bus.col     = '0;
    bus.out_pix = 24'hFFFFFF;
    while (n < N && cyc < 8 * N) begin
      bus.s_valid = ($urandom_range(99) < pct);
      px = ramp ? PIX_W'(n) : PIX_W'($urandom);
      bus.s_pix = px;
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) begin
        mdl[n] = px;
        n++;
      end
      cyc++;
      step();
    end
    bus.s_valid = 1'b0;
    bus.out_we  = 1'b0;
    chk("load_count", n, N);
  endtask

  task automatic read_chk(input logic [5:0] r, input logic [5:0] c);
    bus.row = r;
    bus.col = c;
    @(negedge clk);
    chk("in_pix", 32'(bus.in_pix), 32'(mdl[{r, c}]));
    step();
  endtask

  task automatic run_writes(input int unsigned k, input bit fixed_first);
    logic [5:0] r, c;
    logic [PIX_W-1:0] px;
    for (int unsigned i = 0; i < k; i++) begin
      r  = (fixed_first && i == 0) ? 6'd63 : 6'($urandom);
      c  = (fixed_first && i == 0) ? 6'd63 : 6'($urandom);
      px = (fixed_first && i == 0) ? 24'hABCDEF : PIX_W'($urandom);
      bus.row = r; bus.col = c; bus.out_pix = px; bus.out_we = 1'b1;
      @(negedge clk);
      chk("raw_old", 32'(bus.in_pix), 32'(mdl[{r, c}]));
      step();
      mdl[{r, c}] = px;
      bus.out_we = 1'b0;
      @(negedge clk);
      chk("raw_new", 32'(bus.in_pix), 32'(px));
      step();
    end
  endtask

  task automatic pulse_flag(input int unsigned which, input logic [2:0] exp_status);
    if (which == 0) bus.mirror_done = 1'b1;
    else            bus.gray_done   = 1'b1;
    step();
    bus.mirror_done = 1'b0;
    bus.gray_done   = 1'b0;
    @(negedge clk);
    chk("status_flag", 32'(bus.status), 32'(exp_status));
    chk("run_no_valid", 32'(bus.m_valid), 32'd0);
    step();
  endtask

  // Filter cycle carries a simultaneous engine write, which must land first.
  task automatic do_filter(input logic [2:0] exp_status);
    logic [5:0] r, c;
    logic [PIX_W-1:0] px;
    exp_t e;
    r = 6'($urandom); c = 6'($urandom); px = PIX_W'($urandom);
    bus.row = r; bus.col = c; bus.out_pix = px; bus.out_we = 1'b1;
    bus.filter_done = 1'b1;
    bus.m_ready = 1'b0;
    mdl[{r, c}] = px;
    for (int i = 0; i < N; i++) begin
      e.pix  = mdl[i];
      e.last = (i == N - 1);
      sbq.push_back(e);
    end
    @(negedge clk);
    chk("filter_cycle_no_valid", 32'(bus.m_valid), 32'd0);
    step();
    bus.filter_done = 1'b0;
    bus.out_we      = 1'b0;
    @(negedge clk);
    chk("dump_valid_rise", 32'(bus.m_valid), 32'd1);
    chk("dump_status", 32'(bus.status), 32'(exp_status));
    chk("dump_proc_rst", 32'(bus.proc_rst), 32'd1);
    chk("filter_write", 32'(bus.in_pix), 32'(px));
  endtask

  task automatic dump(input int unsigned mode, input int abort_at);
    int unsigned hs  = 0;
    int unsigned cyc = 0;
    int unsigned fd0 = fd_count;
    bit tog  = 1'b1;
    bit done = 1'b0;
    step();
    while (!done && cyc < 4 * N) begin
      if (abort_at >= 0 && hs == abort_at) begin
        rst = 1'b1;
        bus.m_ready = 1'b0;
        break;
      end
      bus.m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(1));
      tog = !tog;
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) hs++;
      if (bus.frame_done) done = 1'b1;
      cyc++;
      step();
    end
    bus.m_ready = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_reached", hs, abort_at);
      step();
      @(negedge clk);
      chk("abort_m_valid", 32'(bus.m_valid), 32'd0);
      chk("abort_m_last", 32'(bus.m_last), 32'd0);
      chk("abort_status", 32'(bus.status), 32'd0);
      chk("abort_proc_rst", 32'(bus.proc_rst), 32'd1);
      chk("abort_s_ready", 32'(bus.s_ready), 32'd1);
      sbq.delete();
      step();
      rst = 1'b0;
    end else begin
      chk("dump_done_seen", 32'(done), 32'd1);
      chk("dump_handshakes", hs, N);
      @(negedge clk);
      chk("post_done_s_ready", 32'(bus.s_ready), 32'd1);
      chk("post_done_fd_low", 32'(bus.frame_done), 32'd0);
      chk("post_done_status", 32'(bus.status), 32'd0);
      chk("frame_done_pulses", fd_count, fd0 + 1);
      chk("sb_empty", sbq.size(), 0);
      step();
    end
  endtask

  initial begin
    bus.s_pix = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b0;
    bus.row = '0; bus.col = '0; bus.out_we = 1'b0; bus.out_pix = '0;
    bus.mirror_done = 1'b0; bus.gray_done = 1'b0; bus.filter_done = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_proc_rst", 32'(bus.proc_rst), 32'd1);
    chk("rst_status", 32'(bus.status), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
    step();
    rst = 1'b0;

    // Frame 1: ramp load, directed writes and flags, toggling backpressure.
    load_frame(1'b1, 100);
    @(negedge clk);
    chk("load_s_ready_low", 32'(bus.s_ready), 32'd0);
    chk("run_proc_rst_low", 32'(bus.proc_rst), 32'd0);
    step();
    read_chk(6'd0, 6'd0);
    bus.row = 6'd1; bus.col = 6'd2;
    @(negedge clk);
    chk("ramp_1_2", 32'(bus.in_pix), 32'h000042);
    step();
    for (int i = 0; i < 4; i++) read_chk(6'($urandom), 6'($urandom));
    run_writes(6, 1'b1);
    pulse_flag(0, 3'b001);
    pulse_flag(1, 3'b011);
    do_filter(3'b111);
    dump(1, -1);

    // Frame 2: random load with gaps, random backpressure, reset at idx 100.
    load_frame(1'b0, 70);
    @(negedge clk);
    chk("load2_s_ready_low", 32'(bus.s_ready), 32'd0);
    step();
    run_writes(3, 1'b0);
    do_filter(3'b100);
    dump(2, 100);

    // Frame 3: fresh load after abort, 500 RUN cycles, full-rate dump.
    load_frame(1'b0, 85);
    repeat (499) step();
    do_filter(3'b100);
`ifdef RUN_CYCLES_EN
    chk("run_cycles", run_cycles, 32'd500);
`endif
    dump(0, -1);
`ifdef RUN_CYCLES_EN
    chk("run_cycles_held", run_cycles, 32'd500);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_frame_store.md
# image_frame_store

Frame-buffer responder on the far side of the pixel-processing engine's row/col/in_pix/out_we image port. It holds one 64x64 RGB image and loads it from an upstream pixel stream. It then releases the engine from reset and serves its combinational reads and clocked in-place writes. When the engine raises filter_done, it streams the processed image out downstream.

## Interface
Parameters:
- IMG_LOG2, 6, log2 of image side; image is 2^IMG_LOG2 square, depth N = 4^IMG_LOG2
- PIX_W, 24, pixel width (R [23:16], G [15:8], B [7:0])

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- s_pix  in  PIX_W  upstream load pixel, raster order
- s_valid  in  1  load pixel valid
- s_ready  out  1  store accepts load pixel
- m_pix  out  PIX_W  downstream dump pixel, raster order
- m_valid  out  1  dump pixel valid
- m_ready  in  1  downstream accepts
- m_last  out  1  marks pixel N-1 of dump
- row, col  in  IMG_LOG2 each  engine pixel address
- in_pix  out  PIX_W  mem[{row,col}], combinational
- out_we  in  1  engine write enable
- out_pix  in  PIX_W  engine write data
- mirror_done, gray_done, filter_done  in  1 each  engine phase flags
- proc_rst  out  1  holds engine in reset (its FSM starts via default state)
- status  out  3  sticky {filter, gray, mirror} done bits
- frame_done  out  1  one-cycle pulse after final dump handshake

## Operation
- Storage: N x PIX_W array, address {row,col} / raster index; contents not reset.
- FSM: LOAD(0) -> RUN(1) -> DUMP(2) -> DONE(3) -> LOAD.
- LOAD: s_ready=1; on s_valid&s_ready write s_pix to mem[idx], idx++; on the accept with idx=N-1 -> RUN, idx<=0.
- RUN: proc_rst=0; out_we=1 at clock edge writes out_pix to mem[{row,col}]; out_we ignored in all other states. The status bit for a done flag sets when that flag=1 in RUN. filter_done=1 -> DUMP.
- DUMP: m_valid=1, m_pix=mem[idx] combinational, m_last=(idx==N-1); on m_ready idx++; the handshake with m_last -> DONE.
- DONE: frame_done=1 for one cycle; status cleared on entry to LOAD next cycle.
- proc_rst=1 in LOAD, DUMP, DONE.
- in_pix is always mem[{row,col}] regardless of state. A same-cycle read of an address being written returns the old value.

## Timing
- Reset (sampled at edge): state LOAD, idx 0, status 0, frame_done 0, m_valid 0, m_last 0, proc_rst 1. s_ready is 1 from the cycle after the reset edge.
- Load: N cycles minimum at full s_valid; RUN begins the cycle after the last accept.
- Write latency: one edge; read after write returns new data the following cycle.
- DUMP entry: m_valid rises the cycle after filter_done is sampled high in RUN. At full m_ready, N cycles, then DONE for 1 cycle.
- Simultaneous out_we and filter_done: write commits, then DUMP.
- Backpressure: m_pix/m_last stable while m_valid&!m_ready. s_valid low stalls idx.
- Reset mid-operation: aborts any state to LOAD idx 0; partially loaded or processed memory is retained but overwritten by the next load.
- idx is IMG_LOG2*2 bits wide; it wraps naturally at N and is reset explicitly on each transition.

## Configuration
- RUN_CYCLES_EN defined: adds output run_cycles[31:0]. It clears on entry to RUN and increments every RUN cycle, saturating at 0xFFFFFFFF. It holds its value through DUMP/DONE and clears on rst.
- RUN_CYCLES_EN undefined: no port, no counter logic; behaviour otherwise identical.

## Test plan
- Load ramp s_pix=idx with continuous s_valid -> s_ready low after 4096 accepts; proc_rst falls the next cycle; in_pix at row=1,col=2 reads 0x000042.
- RUN, out_we=1 at row=63,col=63 with out_pix=0xABCDEF -> in_pix there reads 0xABCDEF the next cycle; out_we in LOAD leaves memory unchanged.
- Pulse mirror_done, then gray_done, then filter_done -> status 3'b001, 3'b011, 3'b111; m_valid rises the cycle after filter_done.
- Dump with m_ready toggling 1010... -> 4096 handshakes in raster order, m_pix stable when stalled; m_last only on the 4096th; frame_done pulses once; s_ready=1 the cycle after.
- Assert rst midway through DUMP (idx=100) -> next cycle state LOAD, m_valid 0, status 0, proc_rst 1, new load starts at idx 0.
- RUN_CYCLES_EN: filter_done 500 cycles after RUN entry -> run_cycles=500, held through DUMP.
